// File: rtl/forward_pkg.sv
`default_nettype none
// ============================================================================
// Module   : forward_pkg
// Brief    : Shared types for the EXE-stage forwarding / load-use controller.
// Revision : 1.0 - initial release
// ============================================================================
package forward_pkg;

    // Width of the rd field carried in the in-flight tracking entries.
    localparam int c_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_LD  = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        RUN    = 1'b0,
        LDWAIT = 1'b1
    } fwd_state_e;

    typedef struct packed {
        logic [c_REG_ADDR_W-1:0] rd;
        logic                    wr;
        logic                    ld;
    } rd_entry_t;

    localparam rd_entry_t c_BUBBLE = '{rd: '0, wr: 1'b0, ld: 1'b0};

endpackage
`default_nettype wire

// File: rtl/fwd_sel_logic.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_logic
// Brief    : Per-operand forwarding select and load-use hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel_logic
    import forward_pkg::*;
(
    input  logic [c_REG_ADDR_W-1:0] i_rs_addr,
    input  rd_entry_t               i_mem_entry,
    input  logic [c_REG_ADDR_W-1:0] i_wb_rd,
    input  logic                    i_wb_wr,
    input  logic                    i_dcache_valid,
    output fwd_sel_e                o_sel,
    output logic                    o_hazard
);

    logic w_rs_nz;
    logic w_hit_mem;
    logic w_hit_wb;

    // x0 is hard-wired zero, so a write to it is never a producer.
    assign w_rs_nz   = |i_rs_addr;
    assign w_hit_mem = i_mem_entry.wr && (i_rs_addr == i_mem_entry.rd) && w_rs_nz;
    assign w_hit_wb  = i_wb_wr && (i_rs_addr == i_wb_rd) && w_rs_nz;

    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_mem) begin
            if (!i_mem_entry.ld) begin
                o_sel = FWD_MEM;
            end else if (i_dcache_valid) begin
                o_sel = FWD_LD;
            end
        end else if (w_hit_wb) begin
            o_sel = FWD_WB;
        end
    end

    assign o_hazard = w_hit_mem && i_mem_entry.ld && !i_dcache_valid;

endmodule
`default_nettype wire

// File: rtl/forward_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : forward_hazard_ctrl
// Brief    : EXE operand forwarding control with load-use stall and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module forward_hazard_ctrl
    import forward_pkg::*;
#(
    // Must equal the package rd width; the tracking entries are sized from it.
    parameter int REG_ADDR_W = c_REG_ADDR_W,
    parameter int MAX_WAIT   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr_EXE,
    input  logic [REG_ADDR_W-1:0] rs2_addr_EXE,
    input  logic [REG_ADDR_W-1:0] rd_addr_EXE,
    input  logic                  reg_write_EXE,
    input  logic                  mem_read_EXE,
    input  logic                  flush_EXE,
    input  logic                  dcache_stall,
    input  logic                  Dcache_valid,
    output logic [1:0]            rs1_sel,
    output logic [1:0]            rs2_sel,
    output logic                  stall_o,
    output logic                  hazard_timeout
);

    localparam int                 c_CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_WAIT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    rd_entry_t               r_mem;
    logic [REG_ADDR_W-1:0]   r_wb_rd;
    logic                    r_wb_wr;
    fwd_state_e              r_state;
    logic [c_CNT_W-1:0]      r_wait_cnt;
    logic                    r_timeout;

    rd_entry_t               w_exe_entry;
    fwd_sel_e                w_sel1;
    fwd_sel_e                w_sel2;
    logic                    w_haz1;
    logic                    w_haz2;
    logic                    w_ld_hazard;
    logic                    w_stall;

    assign w_exe_entry = '{rd: rd_addr_EXE,
                           wr: reg_write_EXE & ~flush_EXE,
                           ld: mem_read_EXE & ~flush_EXE};

    fwd_sel_logic u_sel_rs1 (
        .i_rs_addr      (rs1_addr_EXE),
        .i_mem_entry    (r_mem),
        .i_wb_rd        (r_wb_rd),
        .i_wb_wr        (r_wb_wr),
        .i_dcache_valid (Dcache_valid),
        .o_sel          (w_sel1),
        .o_hazard       (w_haz1)
    );

    fwd_sel_logic u_sel_rs2 (
        .i_rs_addr      (rs2_addr_EXE),
        .i_mem_entry    (r_mem),
        .i_wb_rd        (r_wb_rd),
        .i_wb_wr        (r_wb_wr),
        .i_dcache_valid (Dcache_valid),
        .o_sel          (w_sel2),
        .o_hazard       (w_haz2)
    );

    assign w_ld_hazard = w_haz1 | w_haz2;
    assign w_stall     = (r_state == LDWAIT) ? ~Dcache_valid : w_ld_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem      <= c_BUBBLE;
            r_wb_rd    <= '0;
            r_wb_wr    <= 1'b0;
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            // The waiting load is never displaced from MEM; younger work stays in EXE.
            if (!dcache_stall) begin
                r_wb_rd <= r_mem.rd;
                r_wb_wr <= r_mem.wr;
                if (!w_stall) begin
                    r_mem <= w_exe_entry;
                end
            end

            case (r_state)
                RUN: begin
                    if (w_ld_hazard && !dcache_stall) begin
                        r_state    <= LDWAIT;
                        r_wait_cnt <= c_CNT_ONE;
                    end
                end
                LDWAIT: begin
                    if (!Dcache_valid) begin
                        if (r_wait_cnt != c_MAX_CNT) begin
                            r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
                        end else begin
                            r_timeout <= 1'b1;
                        end
                    end else if (!dcache_stall) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign rs1_sel        = rst ? FWD_RF : w_sel1;
    assign rs2_sel        = rst ? FWD_RF : w_sel2;
    assign stall_o        = w_stall & ~rst;
    assign hazard_timeout = r_timeout & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_forward_hazard_ctrl
// Brief    : Scoreboard bench: directed hazard scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_forward_hazard_ctrl;

    localparam int c_MAX_WAIT = 4;
    localparam int c_CYCLES   = 3000;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_addr_EXE, rs2_addr_EXE, rd_addr_EXE;
    logic       reg_write_EXE, mem_read_EXE, flush_EXE;
    logic       dcache_stall, Dcache_valid;
    logic [1:0] rs1_sel, rs2_sel;
    logic       stall_o, hazard_timeout;

    always #5 clk = ~clk;

    forward_hazard_ctrl #(
        .REG_ADDR_W (5),
        .MAX_WAIT   (c_MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1_addr_EXE   (rs1_addr_EXE),
        .rs2_addr_EXE   (rs2_addr_EXE),
        .rd_addr_EXE    (rd_addr_EXE),
        .reg_write_EXE  (reg_write_EXE),
        .mem_read_EXE   (mem_read_EXE),
        .flush_EXE      (flush_EXE),
        .dcache_stall   (dcache_stall),
        .Dcache_valid   (Dcache_valid),
        .rs1_sel        (rs1_sel),
        .rs2_sel        (rs2_sel),
        .stall_o        (stall_o),
        .hazard_timeout (hazard_timeout)
    );

    typedef struct {
        logic [1:0] s1;
        logic [1:0] s2;
        logic       st;
        logic       to;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        bit         wr;
        bit         ld;
    } instr_t;

    exp_t   sb_q[$];
    instr_t pipe[2];            // [0] = instruction in MEM, [1] = instruction in WB
    bit     m_waiting;
    int     m_wait_cycles;
    bit     m_timeout;
    bit     m_last_stall;
    int     checks = 0;
    int     errors = 0;

    // Youngest in-flight producer of rs wins; a load in MEM only supplies data once valid.
    function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic dv);
        if (rs == 5'd0) return 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (pipe[k].wr && pipe[k].rd == rs) begin
                if (k == 1) return 2'b10;
                if (!pipe[k].ld) return 2'b01;
                return dv ? 2'b11 : 2'b00;
            end
        end
        return 2'b00;
    endfunction

    function automatic bit m_needs_load(input logic [4:0] rs);
        return (rs != 5'd0) && pipe[0].wr && pipe[0].ld && (pipe[0].rd == rs);
    endfunction

    task automatic step(input bit r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] d, input bit wr, input bit ld, input bit fl,
                        input bit dcs, input bit dv);
        exp_t   e;
        bit     haz;
        instr_t nx;
        @(posedge clk);
        #1;
        rst = r; rs1_addr_EXE = a1; rs2_addr_EXE = a2; rd_addr_EXE = d;
        reg_write_EXE = wr; mem_read_EXE = ld; flush_EXE = fl;
        dcache_stall = dcs; Dcache_valid = dv;

        haz = !dv && (m_needs_load(a1) || m_needs_load(a2));
        if (r) begin
            e = '{2'b00, 2'b00, 1'b0, 1'b0};
        end else begin
            e.s1 = m_sel(a1, dv);
            e.s2 = m_sel(a2, dv);
            e.st = m_waiting ? !dv : haz;
            e.to = m_timeout;
        end
        sb_q.push_back(e);

        if (r) begin
            pipe[0] = '{5'd0, 1'b0, 1'b0};
            pipe[1] = '{5'd0, 1'b0, 1'b0};
            m_waiting = 1'b0; m_wait_cycles = 0; m_timeout = 1'b0;
        end else begin
            if (m_waiting) begin
                if (!dv) begin
                    if (m_wait_cycles >= c_MAX_WAIT) m_timeout = 1'b1;
                    m_wait_cycles++;
                end else if (!dcs) begin
                    m_waiting = 1'b0;
                end
            end else if (haz && !dcs) begin
                m_waiting = 1'b1;
                m_wait_cycles = 1;
            end
            if (!dcs) begin
                nx = '{d, wr && !fl, ld && !fl};
                pipe[1] = pipe[0];
                if (!e.st) pipe[0] = nx;
            end
        end
        m_last_stall = e.st && !r;
    endtask

    task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp("rs1_sel", rs1_sel, e.s1);
                cmp("rs2_sel", rs2_sel, e.s2);
                cmp("stall_o", {1'b0, stall_o}, {1'b0, e.st});
                cmp("hazard_timeout", {1'b0, hazard_timeout}, {1'b0, e.to});
            end
        end
    end

    initial begin : driver
        logic [4:0] ra1, ra2, rd;
        bit         rw, rl, rf, rr, rdcs, rdv;
        rst = 1'b1; rs1_addr_EXE = '0; rs2_addr_EXE = '0; rd_addr_EXE = '0;
        reg_write_EXE = 1'b0; mem_read_EXE = 1'b0; flush_EXE = 1'b0;
        dcache_stall = 1'b0; Dcache_valid = 1'b0;
        m_waiting = 1'b0; m_wait_cycles = 0; m_timeout = 1'b0; m_last_stall = 1'b0;
        pipe[0] = '{5'd0, 1'b0, 1'b0};
        pipe[1] = '{5'd0, 1'b0, 1'b0};

        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ALU chain: add x5 then consume x5 as rs1
        step(1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd5, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Distance two, then the same through x0
        step(1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load-use with three invalid cycles
        step(1'b0, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // MEM wins over WB for the same rd
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Timeout: data never arrives until long after the limit
        step(1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset while waiting, then a flushed producer
        step(1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd4, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // External stall coinciding with a load-use
        step(1'b0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd6, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd6, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        ra1 = '0; ra2 = '0; rd = '0; rw = 1'b0; rl = 1'b0; rf = 1'b0;
        for (int i = 0; i < c_CYCLES; i++) begin
            if (!m_last_stall) begin
                ra1 = 5'($urandom_range(0, 7));
                ra2 = 5'($urandom_range(0, 7));
                rd  = 5'($urandom_range(0, 7));
                rw  = ($urandom_range(0, 99) < 70);
                rl  = ($urandom_range(0, 99) < 30);
                rf  = ($urandom_range(0, 99) < 10);
            end
            rr   = ($urandom_range(0, 99) < 2);
            rdcs = ($urandom_range(0, 99) < 10);
            rdv  = ($urandom_range(0, 99) < 30);
            step(rr, ra1, ra2, rd, rw, rl, rf, rdcs, rdv);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
